// File: rtl/resdmac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | resdmac_pkg : shared arbiter state encoding and default tenure limits       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package resdmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SYNC    = 3'd2,
    ST_OWNED   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_HOLDOFF = 3'd5
  } arb_state_t;

  localparam int MAX_CYCLES_DEF = 16;
  localparam int HOLDOFF_DEF    = 4;
  localparam int BG_TIMEOUT_DEF = 255;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync2 : two-flop synchroniser for asynchronous bus pins                     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Reset to the pin's inactive level so the FSM never sees a false grant.
  always_ff @(posedge clk) begin
    if (!rst_n_i) sync_q <= {2{RST_VAL}};
    else          sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/bus_tenure_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_tenure_arbiter : 68030 BR/BG/BGACK mastership sequencer for the DMA     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module bus_tenure_arbiter
  import resdmac_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int HOLDOFF    = HOLDOFF_DEF,
  parameter int BG_TIMEOUT = BG_TIMEOUT_DEF
) (
  input  logic       SCLK,
  input  logic       _RST,
  input  logic       DMAENA,
  input  logic       XFER_REQ,
  input  logic       CYC_START,
  input  logic       CYC_DONE,
  input  logic       BERR_,
  input  logic       _BG,
  input  logic       _BGACK_I,
  input  logic       _AS_I,
  output logic       BREQ,
  output logic       OWN,
  output logic       CYC_OK,
  output logic       TENURE_END,
  output logic       ARB_ERR,
  output logic [7:0] CYC_CNT
);

  localparam logic [7:0] MAX_CNT  = 8'(MAX_CYCLES);
  localparam logic [7:0] TO_LAST  = 8'(BG_TIMEOUT - 1);
  localparam logic [7:0] HO_LAST  = 8'(HOLDOFF - 1);
  localparam arb_state_t REL_NEXT = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;

  arb_state_t state_q, state_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [7:0] ho_cnt_q, ho_cnt_d;
  logic [7:0] cyc_cnt_q, cyc_cnt_d;
  logic       inflight_q, inflight_d;
  logic       arb_err_q, arb_err_d;
  logic       tend_q, tend_d;
  logic       bg_s, bgack_s, as_s;
  logic       bus_idle;
  logic       flight_after;
  logic       own_exit;

  sync2 #(.RST_VAL(1'b1)) u_sync_bg    (.clk(SCLK), .rst_n_i(_RST), .d_i(_BG),      .q_o(bg_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_bgack (.clk(SCLK), .rst_n_i(_RST), .d_i(_BGACK_I), .q_o(bgack_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_as    (.clk(SCLK), .rst_n_i(_RST), .d_i(_AS_I),    .q_o(as_s));

  assign bus_idle = as_s & bgack_s;

  // A termination wins over a same-clock start, so the flag ends up clear.
  assign flight_after = CYC_DONE ? 1'b0 : (CYC_START | inflight_q);

  assign own_exit = (state_q == ST_DRAIN) | ~XFER_REQ | ~DMAENA |
                    (cyc_cnt_q == MAX_CNT) | (CYC_DONE & ~BERR_);

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    ho_cnt_d   = ho_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    inflight_d = 1'b0;
    arb_err_d  = arb_err_q;
    tend_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_cnt_d = 8'd0;
        if (!DMAENA)       arb_err_d = 1'b0;
        else if (XFER_REQ) state_d   = ST_REQ;
      end

      ST_REQ, ST_SYNC: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (!DMAENA) begin
          state_d = ST_IDLE;
        end else if (state_q == ST_SYNC && bus_idle) begin
          state_d   = ST_OWNED;
          cyc_cnt_d = 8'd0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          arb_err_d = 1'b1;
        end else if (state_q == ST_REQ && !bg_s) begin
          state_d = ST_SYNC;
        end else if (state_q == ST_SYNC && bg_s) begin
          state_d = ST_REQ;
        end
      end

      ST_OWNED, ST_DRAIN: begin
        inflight_d = flight_after;
        if (CYC_DONE) begin
          if (cyc_cnt_q != 8'hFF) cyc_cnt_d = cyc_cnt_q + 8'd1;
          if (!BERR_)             arb_err_d = 1'b1;
        end
        // Release straight from OWNED when nothing is left in flight.
        if (own_exit) begin
          if (!flight_after) begin
            state_d  = REL_NEXT;
            tend_d   = 1'b1;
            ho_cnt_d = 8'd0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_HOLDOFF: begin
        ho_cnt_d = ho_cnt_q + 8'd1;
        if (ho_cnt_q == HO_LAST) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      state_q    <= ST_IDLE;
      to_cnt_q   <= 8'd0;
      ho_cnt_q   <= 8'd0;
      cyc_cnt_q  <= 8'd0;
      inflight_q <= 1'b0;
      arb_err_q  <= 1'b0;
      tend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      ho_cnt_q   <= ho_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      inflight_q <= inflight_d;
      arb_err_q  <= arb_err_d;
      tend_q     <= tend_d;
    end
  end

  assign BREQ       = (state_q == ST_REQ) | (state_q == ST_SYNC);
  assign OWN        = (state_q == ST_OWNED) | (state_q == ST_DRAIN);
  assign CYC_OK     = (state_q == ST_OWNED) & XFER_REQ & DMAENA & ~inflight_q &
                      (cyc_cnt_q < MAX_CNT);
  assign TENURE_END = tend_q;
  assign ARB_ERR    = arb_err_q;
  assign CYC_CNT    = cyc_cnt_q;

  a_start_needs_ok: assert property (@(posedge SCLK) disable iff (!_RST) CYC_START |-> CYC_OK);

endmodule
`default_nettype wire

// File: tb/tb_bus_tenure_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_tenure_arbiter : directed self-checking bench for bus_tenure_arbiter |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_bus_tenure_arbiter;

  logic       SCLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       DMAENA = 1'b0;
  logic       XFER_REQ = 1'b0;
  logic       CYC_START = 1'b0;
  logic       CYC_DONE = 1'b0;
  logic       berr_n = 1'b1;
  logic       bg_n = 1'b1;
  logic       bgack_n = 1'b1;
  logic       as_n = 1'b1;
  logic       BREQ, OWN, CYC_OK, TENURE_END, ARB_ERR;
  logic [7:0] CYC_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  bus_tenure_arbiter #(.MAX_CYCLES(16), .HOLDOFF(4), .BG_TIMEOUT(255)) dut (
    .SCLK      (SCLK),
    ._RST      (rst_n),
    .DMAENA    (DMAENA),
    .XFER_REQ  (XFER_REQ),
    .CYC_START (CYC_START),
    .CYC_DONE  (CYC_DONE),
    .BERR_     (berr_n),
    ._BG       (bg_n),
    ._BGACK_I  (bgack_n),
    ._AS_I     (as_n),
    .BREQ      (BREQ),
    .OWN       (OWN),
    .CYC_OK    (CYC_OK),
    .TENURE_END(TENURE_END),
    .ARB_ERR   (ARB_ERR),
    .CYC_CNT   (CYC_CNT)
  );

  always #5 SCLK = ~SCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic do_reset(input logic xfer, input logic ena);
    rst_n = 1'b0; CYC_START = 1'b0; CYC_DONE = 1'b0; berr_n = 1'b1;
    bg_n = 1'b1; bgack_n = 1'b1; as_n = 1'b1;
    XFER_REQ = xfer; DMAENA = ena;
    tick(); tick(); tick();
    rst_n = 1'b1;
  endtask

  // BREQ appears one clock after reset release; grant arrives 3 clocks later.
  task automatic grant(input int n_after);
    tick();
    repeat (3) tick();
    bg_n = 1'b0;
    repeat (n_after) tick();
  endtask

  task automatic bus_cycle(input logic e_n);
    if (CYC_OK === 1'b1) begin
      CYC_START = 1'b1; tick(); CYC_START = 1'b0;
      CYC_DONE = 1'b1; berr_n = e_n; tick(); CYC_DONE = 1'b0; berr_n = 1'b1;
    end else begin
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; XFER_REQ = 1'b1; DMAENA = 1'b1;
    tick(); tick();
    n_checks++; if (BREQ !== 1'b0) $display("FAIL reset_breq: got %b want 0", BREQ); else n_pass++;
    n_checks++; if (OWN !== 1'b0) $display("FAIL reset_own: got %b want 0", OWN); else n_pass++;
    n_checks++; if (CYC_OK !== 1'b0) $display("FAIL reset_cyc_ok: got %b want 0", CYC_OK); else n_pass++;
    n_checks++; if (TENURE_END !== 1'b0) $display("FAIL reset_tenure_end: got %b want 0", TENURE_END); else n_pass++;
    n_checks++; if (ARB_ERR !== 1'b0) $display("FAIL reset_arb_err: got %b want 0", ARB_ERR); else n_pass++;
    n_checks++; if (CYC_CNT !== 8'd0) $display("FAIL reset_cyc_cnt: got %0d want 0", CYC_CNT); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++; if (BREQ !== 1'b1) $display("FAIL reset_exit_breq: got %b want 1", BREQ); else n_pass++;
  endtask

  task automatic test_basic_tenure();
    int breq_hi;
    do_reset(1'b1, 1'b1);
    tick();
    repeat (3) tick();
    bg_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (OWN !== 1'b0 || BREQ !== 1'b1)
      $display("FAIL basic_pre_own: OWN=%b BREQ=%b want OWN=0 BREQ=1", OWN, BREQ); else n_pass++;
    tick();
    n_checks++; if (OWN !== 1'b1 || BREQ !== 1'b0)
      $display("FAIL basic_own_rise: OWN=%b BREQ=%b want OWN=1 BREQ=0", OWN, BREQ); else n_pass++;
    n_checks++; if (CYC_OK !== 1'b1 || CYC_CNT !== 8'd0)
      $display("FAIL basic_own_start: CYC_OK=%b CYC_CNT=%0d want 1/0", CYC_OK, CYC_CNT); else n_pass++;
    for (int i = 0; i < 16; i++) bus_cycle(1'b1);
    n_checks++; if (CYC_CNT !== 8'd16 || OWN !== 1'b1 || CYC_OK !== 1'b0)
      $display("FAIL basic_limit: CYC_CNT=%0d OWN=%b CYC_OK=%b want 16/1/0", CYC_CNT, OWN, CYC_OK); else n_pass++;
    tick();
    n_checks++; if (OWN !== 1'b0 || TENURE_END !== 1'b1 || BREQ !== 1'b0)
      $display("FAIL basic_release: OWN=%b TENURE_END=%b BREQ=%b want 0/1/0", OWN, TENURE_END, BREQ); else n_pass++;
    tick();
    n_checks++; if (TENURE_END !== 1'b0)
      $display("FAIL basic_tenure_pulse: got %b want 0", TENURE_END); else n_pass++;
    breq_hi = (BREQ !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (BREQ !== 1'b0) breq_hi++;
    end
    n_checks++; if (breq_hi != 0)
      $display("FAIL basic_holdoff: BREQ high on %0d holdoff clocks want 0", breq_hi); else n_pass++;
    tick();
    tick();
    n_checks++; if (BREQ !== 1'b1)
      $display("FAIL basic_rerequest: BREQ=%b want 1", BREQ); else n_pass++;
  endtask

  task automatic test_early_drop();
    do_reset(1'b1, 1'b1);
    grant(4);
    for (int i = 0; i < 5; i++) bus_cycle(1'b1);
    n_checks++; if (CYC_CNT !== 8'd5 || CYC_OK !== 1'b1)
      $display("FAIL drop_five: CYC_CNT=%0d CYC_OK=%b want 5/1", CYC_CNT, CYC_OK); else n_pass++;
    if (CYC_OK === 1'b1) CYC_START = 1'b1;
    tick();
    CYC_START = 1'b0;
    XFER_REQ = 1'b0;
    repeat (3) tick();
    n_checks++; if (OWN !== 1'b1 || CYC_OK !== 1'b0)
      $display("FAIL drop_hold: OWN=%b CYC_OK=%b want 1/0", OWN, CYC_OK); else n_pass++;
    CYC_DONE = 1'b1;
    tick();
    CYC_DONE = 1'b0;
    n_checks++; if (OWN !== 1'b0 || TENURE_END !== 1'b1)
      $display("FAIL drop_release: OWN=%b TENURE_END=%b want 0/1", OWN, TENURE_END); else n_pass++;
    n_checks++; if (CYC_CNT !== 8'd6)
      $display("FAIL drop_count: CYC_CNT=%0d want 6", CYC_CNT); else n_pass++;
  endtask

  task automatic test_busy_bus();
    int own_seen;
    int lat;
    do_reset(1'b1, 1'b1);
    bgack_n = 1'b0;
    grant(3);
    own_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (OWN !== 1'b0) own_seen++;
    end
    n_checks++; if (own_seen != 0)
      $display("FAIL busy_no_own: OWN seen on %0d clocks want 0", own_seen); else n_pass++;
    n_checks++; if (BREQ !== 1'b1)
      $display("FAIL busy_breq: BREQ=%b want 1", BREQ); else n_pass++;
    bgack_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (lat == 0 && OWN === 1'b1) lat = i;
    end
    n_checks++; if (lat != 3)
      $display("FAIL busy_own_latency: got %0d clocks (0 = never) want 3", lat); else n_pass++;
  endtask

  task automatic test_bg_timeout();
    do_reset(1'b1, 1'b1);
    repeat (255) tick();
    n_checks++; if (BREQ !== 1'b1 || ARB_ERR !== 1'b0)
      $display("FAIL timeout_last_req: BREQ=%b ARB_ERR=%b want 1/0", BREQ, ARB_ERR); else n_pass++;
    tick();
    n_checks++; if (BREQ !== 1'b0 || ARB_ERR !== 1'b1 || OWN !== 1'b0)
      $display("FAIL timeout_abort: BREQ=%b ARB_ERR=%b OWN=%b want 0/1/0", BREQ, ARB_ERR, OWN); else n_pass++;
    tick();
    n_checks++; if (BREQ !== 1'b1 || ARB_ERR !== 1'b1)
      $display("FAIL timeout_sticky: BREQ=%b ARB_ERR=%b want 1/1", BREQ, ARB_ERR); else n_pass++;
    DMAENA = 1'b0;
    tick();
    n_checks++; if (BREQ !== 1'b0 || ARB_ERR !== 1'b1)
      $display("FAIL timeout_disable: BREQ=%b ARB_ERR=%b want 0/1", BREQ, ARB_ERR); else n_pass++;
    tick();
    n_checks++; if (ARB_ERR !== 1'b0)
      $display("FAIL timeout_clear: ARB_ERR=%b want 0", ARB_ERR); else n_pass++;
  endtask

  task automatic test_bus_error();
    do_reset(1'b1, 1'b1);
    grant(4);
    bus_cycle(1'b1);
    bus_cycle(1'b1);
    n_checks++; if (ARB_ERR !== 1'b0 || OWN !== 1'b1)
      $display("FAIL berr_pre: ARB_ERR=%b OWN=%b want 0/1", ARB_ERR, OWN); else n_pass++;
    bus_cycle(1'b0);
    n_checks++; if (OWN !== 1'b0 || TENURE_END !== 1'b1)
      $display("FAIL berr_release: OWN=%b TENURE_END=%b want 0/1", OWN, TENURE_END); else n_pass++;
    n_checks++; if (ARB_ERR !== 1'b1 || CYC_CNT !== 8'd3)
      $display("FAIL berr_state: ARB_ERR=%b CYC_CNT=%0d want 1/3", ARB_ERR, CYC_CNT); else n_pass++;
  endtask

  task automatic test_reset_mid_tenure();
    do_reset(1'b1, 1'b1);
    grant(4);
    bus_cycle(1'b1);
    if (CYC_OK === 1'b1) CYC_START = 1'b1;
    tick();
    CYC_START = 1'b0;
    n_checks++; if (OWN !== 1'b1 || CYC_CNT !== 8'd1)
      $display("FAIL rstmid_pre: OWN=%b CYC_CNT=%0d want 1/1", OWN, CYC_CNT); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_checks++; if ({BREQ, OWN, CYC_OK, TENURE_END, ARB_ERR} !== 5'b0)
      $display("FAIL rstmid_flags: BREQ,OWN,CYC_OK,TENURE_END,ARB_ERR=%b want 00000",
               {BREQ, OWN, CYC_OK, TENURE_END, ARB_ERR}); else n_pass++;
    n_checks++; if (CYC_CNT !== 8'd0)
      $display("FAIL rstmid_count: CYC_CNT=%0d want 0", CYC_CNT); else n_pass++;
    rst_n = 1'b1;
    XFER_REQ = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_tenure();
    test_early_drop();
    test_busy_bus();
    test_bg_timeout();
    test_bus_error();
    test_reset_mid_tenure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
